march_test_sequencer: RTL and testbench

//  Self-contained March C- sequencer that drives the dut_mem model port (ena/wea/addra/dina, douta back).
//  It sits beside axis2model_if as an alternative master of the same model port; a board-level mux selects which one drives.

---
 rtl/march_test_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_march_test_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/march_test_sequencer.sv
// March C- memory test sequencer driving a single-port memory model port.
// Ports: core_clk/rst, start/abort/bg_pattern control; ena/wea/addra/dina/douta
// model port; busy/done/pass/err_cnt/fail_* status towards the loadboard core.
module march_test_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 65536,
    parameter int READ_LAT    = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              core_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] bg_pattern,
    output logic              ena_model,
    output logic              wea_model,
    output logic [ADDR_W-1:0] addra_model,
    output logic [DATA_W-1:0] dina_model,
    input  logic [DATA_W-1:0] douta_model,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [2:0]        fail_elem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT  = 2'(READ_LAT);

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;
    logic [DATA_W-1:0] d0_q, d0_d;
    logic [15:0]       err_q, err_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fexp_q, fexp_d;
    logic [DATA_W-1:0] fgot_q, fgot_d;
    logic [2:0]        felem_q, felem_d;

    // Element attributes: E3/E4 walk down; odd elements read D0,
    // even elements write D0; E5 is read-only.
    logic              down, has_wr, term, miss;
    logic [DATA_W-1:0] exp_data, wr_data;

    // Where the sequence goes once the current address is finished.
    state_t            adv_state;
    logic [2:0]        adv_elem;
    logic [ADDR_W-1:0] adv_addr;

    always_comb begin
        down     = (elem_q == 3'd3) || (elem_q == 3'd4);
        has_wr   = (elem_q != 3'd5);
        term     = down ? (addr_q == '0) : (addr_q == LAST);
        exp_data = elem_q[0] ? d0_q : ~d0_q;
        wr_data  = elem_q[0] ? ~d0_q : d0_q;
        miss     = (douta_model != exp_data);
    end

    always_comb begin
        adv_state = state_q;
        adv_elem  = elem_q;
        adv_addr  = addr_q;
        if (!term) begin
            adv_addr  = down ? addr_q - 1'b1 : addr_q + 1'b1;
            adv_state = (elem_q == 3'd0) ? S_WR : S_RD;
        end else if (elem_q == 3'd5) begin
            adv_state = S_DONE;
        end else begin
            adv_elem  = elem_q + 3'd1;
            // E2->E3 and E3->E4 enter a descending element.
            adv_addr  = (elem_q == 3'd2 || elem_q == 3'd3) ? LAST : '0;
            adv_state = S_RD;
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        d0_d        = d0_q;
        err_d       = err_q;
        pass_d      = pass_q;
        faddr_d     = faddr_q;
        fexp_d      = fexp_q;
        fgot_d      = fgot_q;
        felem_d     = felem_q;
        ena_model   = 1'b0;
        wea_model   = 1'b0;
        addra_model = '0;
        dina_model  = '0;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = pass_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    d0_d    = bg_pattern;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fgot_d  = '0;
                    felem_d = '0;
                end
            end
            S_WR: begin
                ena_model   = 1'b1;
                wea_model   = 1'b1;
                addra_model = addr_q;
                dina_model  = wr_data;
                busy        = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    state_d = adv_state;
                    elem_d  = adv_elem;
                    addr_d  = adv_addr;
                end
            end
            S_RD: begin
                ena_model   = 1'b1;
                addra_model = addr_q;
                busy        = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_RWAIT;
                    lat_d   = 2'd1;
                end
            end
            S_RWAIT: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (lat_q != LAT) begin
                    lat_d = lat_q + 2'd1;
                end else begin
                    if (miss) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (err_q == '0) begin
                            faddr_d = addr_q;
                            fexp_d  = exp_data;
                            fgot_d  = douta_model;
                            felem_d = elem_q;
                        end
                    end
                    if (miss && STOP_ON_ERR != 0) begin
                        state_d = S_DONE;
                    end else if (has_wr) begin
                        state_d = S_WR;
                    end else begin
                        state_d = adv_state;
                        elem_d  = adv_elem;
                        addr_d  = adv_addr;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                pass    = (err_q == '0);
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            lat_q   <= '0;
            d0_q    <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            faddr_q <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            felem_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            d0_q    <= d0_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            faddr_q <= faddr_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
            felem_q <= felem_d;
        end
    end

    assign err_cnt   = err_q;
    assign fail_addr = faddr_q;
    assign fail_exp  = fexp_q;
    assign fail_got  = fgot_q;
    assign fail_elem = felem_q;

endmodule

// File: tb/tb_march_test_sequencer.sv
// Bench for march_test_sequencer: two instances (16 words/lat 1/run-through,
// 5 words/lat 3/stop-on-error), a faultable memory model and a scoreboard.
`timescale 1ns/1ps
module tb_march_test_sequencer;

    localparam int DEP_A = 16;
    localparam int RL_A  = 1;
    localparam int DEP_B = 5;
    localparam int RL_B  = 3;

    typedef struct {
        int         off;
        bit         we;
        int         a;
        logic [7:0] d;
    } acc_t;

    typedef struct {
        int         cyc;
        bit         ok;
        int         errs;
        int         fa;
        logic [7:0] fe;
        logic [7:0] fg;
        int         fel;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start_s, abort_s, ena, wea, busy, done, pass;
    logic [7:0]  bg [2];
    logic [7:0]  din [2];
    logic [7:0]  dout [2];
    logic [15:0] addr [2];
    logic [15:0] err [2];
    logic [15:0] faddr [2];
    logic [7:0]  fexp [2];
    logic [7:0]  fgot [2];
    logic [2:0]  felem [2];

    int cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    acc_t accq [2][$];
    res_t resq [2][$];
    int   t0 [2];
    int   last_off [2];
    bit   exp_pass [2];

    // Memory model with an optional read-side stuck-at fault per instance.
    logic [7:0] mem [2][16];
    logic [7:0] pipe [2][3];
    bit         fen [2];
    int         fa [2];
    logic [7:0] s0m [2];
    logic [7:0] s1m [2];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    march_test_sequencer #(
        .ADDR_W(16), .DATA_W(8), .DEPTH(DEP_A),
        .READ_LAT(RL_A), .STOP_ON_ERR(0)
    ) dut_a (
        .core_clk(clk), .rst(rst),
        .start(start_s[0]), .abort(abort_s[0]), .bg_pattern(bg[0]),
        .ena_model(ena[0]), .wea_model(wea[0]), .addra_model(addr[0]),
        .dina_model(din[0]), .douta_model(dout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]),
        .fail_addr(faddr[0]), .fail_exp(fexp[0]), .fail_got(fgot[0]),
        .fail_elem(felem[0])
    );

    march_test_sequencer #(
        .ADDR_W(16), .DATA_W(8), .DEPTH(DEP_B),
        .READ_LAT(RL_B), .STOP_ON_ERR(1)
    ) dut_b (
        .core_clk(clk), .rst(rst),
        .start(start_s[1]), .abort(abort_s[1]), .bg_pattern(bg[1]),
        .ena_model(ena[1]), .wea_model(wea[1]), .addra_model(addr[1]),
        .dina_model(din[1]), .douta_model(dout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]),
        .fail_addr(faddr[1]), .fail_exp(fexp[1]), .fail_got(fgot[1]),
        .fail_elem(felem[1])
    );

    function automatic logic [7:0] rd_val(int k, int a, logic [7:0] v);
        if (fen[k] && a == fa[k]) return (v & ~s0m[k]) | s1m[k];
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ena[k] && wea[k]) mem[k][addr[k][3:0]] <= din[k];
            pipe[k][0] <= (ena[k] && !wea[k])
                ? rd_val(k, int'(addr[k]), mem[k][addr[k][3:0]]) : 8'hEE;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    assign dout[0] = pipe[0][RL_A-1];
    assign dout[1] = pipe[1][RL_B-1];

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: walk March C- element by element over an array memory,
    // timestamping each port access by its cycle cost.
    task automatic model(input int k, input int dep, input int rl,
                         input bit stop, input logic [7:0] b);
        logic [7:0] m [16];
        logic [7:0] rv, ev, d1;
        int   off, errs, a;
        bit   halt;
        res_t r;
        acc_t x;
        off  = 0;
        errs = 0;
        halt = 0;
        d1   = ~b;
        r = '{cyc: 0, ok: 1'b1, errs: 0, fa: 0, fe: 8'h0, fg: 8'h0, fel: 0};
        for (int i = 0; i < 16; i++) m[i] = 8'h0;
        for (int e = 0; e < 6 && !halt; e++) begin
            for (int i = 0; i < dep && !halt; i++) begin
                a = (e == 3 || e == 4) ? dep - 1 - i : i;
                if (e != 0) begin
                    off++;
                    x.off = off; x.we = 1'b0; x.a = a; x.d = 8'h0;
                    accq[k].push_back(x);
                    off += rl;
                    ev = (e == 2 || e == 4) ? d1 : b;
                    rv = m[a];
                    if (fen[k] && a == fa[k]) rv = (rv & ~s0m[k]) | s1m[k];
                    if (rv != ev) begin
                        if (errs == 0) begin
                            r.fa = a; r.fe = ev; r.fg = rv; r.fel = e;
                        end
                        errs++;
                        if (stop) halt = 1;
                    end
                end
                if (e != 5 && !halt) begin
                    m[a] = (e == 1 || e == 3) ? d1 : b;
                    off++;
                    x.off = off; x.we = 1'b1; x.a = a; x.d = m[a];
                    accq[k].push_back(x);
                end
            end
        end
        r.cyc  = off + 1;
        r.ok   = (errs == 0);
        r.errs = errs;
        exp_pass[k] = r.ok;
        resq[k].push_back(r);
    endtask

    acc_t mx;
    res_t mr;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (ena[k]) begin
                if (accq[k].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexp_acc[%0d]: got access addr %0h, expected none",
                             k, addr[k]);
                end else begin
                    mx = accq[k].pop_front();
                    check("acc_off", cnt - t0[k], mx.off);
                    check("acc_we", wea[k], mx.we);
                    check("acc_addr", addr[k], mx.a);
                    check("acc_busy", busy[k], 1);
                    if (mx.we) check("acc_data", din[k], mx.d);
                end
            end
            if (done[k]) begin
                last_off[k] = cnt - t0[k];
                if (resq[k].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexp_done[%0d]: got done pulse, expected none", k);
                end else begin
                    mr = resq[k].pop_front();
                    check("done_off", cnt - t0[k], mr.cyc);
                    check("done_busy", busy[k], 0);
                    check("pass", pass[k], mr.ok);
                    check("err_cnt", err[k], mr.errs);
                    check("fail_addr", faddr[k], mr.fa);
                    check("fail_exp", fexp[k], mr.fe);
                    check("fail_got", fgot[k], mr.fg);
                    check("fail_elem", felem[k], mr.fel);
                end
            end
        end
    end

    function automatic int dep_of(int k);
        return (k == 1) ? DEP_B : DEP_A;
    endfunction

    function automatic int rl_of(int k);
        return (k == 1) ? RL_B : RL_A;
    endfunction

    task automatic start_run(input int k, input logic [7:0] b, input bit ab);
        @(negedge clk);
        bg[k]      = b;
        start_s[k] = 1'b1;
        abort_s[k] = ab;
        t0[k]      = cnt;
        model(k, dep_of(k), rl_of(k), k == 1, b);
        @(negedge clk);
        start_s[k] = 1'b0;
        abort_s[k] = 1'b0;
        bg[k]      = 8'($urandom);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (resq[k].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout", resq[k].size(), 0);
        check("acc_left", accq[k].size(), 0);
        @(negedge clk);
        check("pass_held", pass[k], exp_pass[k]);
        check("idle_busy", busy[k], 0);
    endtask

    task automatic check_rst(input int k);
        check("rst_port", {ena[k], wea[k], addr[k], din[k],
                           busy[k], done[k], pass[k]}, 0);
        check("rst_res", {err[k], faddr[k], fexp[k], fgot[k], felem[k]}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        rst     = 1'b1;
        start_s = '0;
        abort_s = '0;
        bg[0]   = 8'h0;
        bg[1]   = 8'h0;
        for (int i = 0; i < 2; i++) begin
            fen[i] = 0; fa[i] = 0; s0m[i] = 8'h0; s1m[i] = 8'h0;
        end
        repeat (3) @(negedge clk);
        check_rst(0);
        check_rst(1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good memory, 16 words, latency 1.
        start_run(0, 8'h55, 0);
        wait_done(0);
        check("t1_len", last_off[0], 241);

        // Bit 0 stuck at 1 on reads of address 5.
        fen[0] = 1; fa[0] = 5; s1m[0] = 8'h01; s0m[0] = 8'h00;
        start_run(0, 8'h00, 0);
        wait_done(0);
        check("t2_err", err[0], 3);
        check("t2_addr", faddr[0], 5);
        check("t2_got", fgot[0], 8'h01);
        check("t2_elem", felem[0], 1);
        fen[0] = 0;

        // Abort in cycle 50 of a good run.
        start_run(0, 8'h55, 0);
        while (cnt - t0[0] < 50) @(negedge clk);
        abort_s[0] = 1'b1;
        accq[0].delete();
        resq[0].delete();
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_ena", ena[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_pass", pass[0], 0);
        repeat (10) @(negedge clk);
        start_run(0, 8'h55, 0);
        wait_done(0);
        check("t4_len", last_off[0], 241);

        // Reset in the middle of E3, restart 2 cycles after release.
        start_run(0, 8'h55, 0);
        while (cnt - t0[0] < 120) @(negedge clk);
        rst = 1'b1;
        accq[0].delete();
        resq[0].delete();
        #1;
        check_rst(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_run(0, 8'h55, 0);
        repeat (30) @(negedge clk);
        bg[0]      = 8'h3C;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0);
        check("t5_len", last_off[0], 241);

        // Stop-on-error instance: fault at address 3 ends the run in E1.
        fen[1] = 1; fa[1] = 3; s1m[1] = 8'h01; s0m[1] = 8'h00;
        start_run(1, 8'h00, 0);
        wait_done(1);
        check("t3_err", err[1], 1);
        check("t3_addr", faddr[1], 3);
        check("t3_elem", felem[1], 1);
        repeat (10) @(negedge clk);
        fen[1] = 0;

        // Good memory, 5 words, latency 3.
        start_run(1, 8'hA7, 0);
        wait_done(1);
        check("t6_len", last_off[1], 126);

        // Randomized runs with random backgrounds and stuck-at faults.
        for (int n = 0; n < 8; n++) begin
            k      = n % 2;
            fen[k] = ($urandom_range(0, 1) == 1);
            fa[k]  = $urandom_range(0, dep_of(k) - 1);
            s1m[k] = 8'($urandom);
            s0m[k] = 8'($urandom) & ~s1m[k];
            repeat ($urandom_range(1, 5)) @(negedge clk);
            start_run(k, 8'($urandom), n == 2 || n == 5);
            wait_done(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
